// File: rtl/chip8_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : chip8_keypad_scanner
// Purpose  : Scans a 4x4 hex keypad matrix one active-low column at a time.
//            The row inputs are synchronised and assembled into a 16-bit frame.
//            A frame is committed to keys_raw only after it has been seen
//            identically for DEBOUNCE_FRAMES consecutive frames.
// Ports    : clk          - system clock (single domain)
//            reset        - synchronous, active-high reset
//            row_n[3:0]   - matrix rows, active-low, asynchronous to clk
//            col_n[3:0]   - matrix column drive, active-low, one-hot low
//            keys_raw     - debounced key vector, bit n = hex key n held
//            keys_changed - one-cycle pulse in the cycle keys_raw changes
// Revision : 1.0 - initial release
// ============================================================================
module chip8_keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [15:0] keys_raw,
    output logic        keys_changed
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_div_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [3:0]       c_debounce = 4'(DEBOUNCE_FRAMES);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (SCAN_DIV < 4) begin : g_bad_scan_div
            $error("chip8_keypad_scanner: SCAN_DIV must be >= 4");
        end
        if ((DEBOUNCE_FRAMES < 1) || (DEBOUNCE_FRAMES > 15)) begin : g_bad_debounce
            $error("chip8_keypad_scanner: DEBOUNCE_FRAMES must be in 1..15");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Key position lookup: hex key -> matrix row / column.
    // Layout (rows top to bottom, columns left to right):
    //   r0: 1 2 3 C
    //   r1: 4 5 6 D
    //   r2: 7 8 9 E
    //   r3: A 0 B F
    // ------------------------------------------------------------------------
    function automatic logic [1:0] key_row(input int k);
        case (k)
            1, 2, 3, 12:   key_row = 2'd0;
            4, 5, 6, 13:   key_row = 2'd1;
            7, 8, 9, 14:   key_row = 2'd2;
            default:       key_row = 2'd3;   // 10, 0, 11, 15
        endcase
    endfunction

    function automatic logic [1:0] key_col(input int k);
        case (k)
            1, 4, 7, 10:   key_col = 2'd0;
            2, 5, 8, 0:    key_col = 2'd1;
            3, 6, 9, 11:   key_col = 2'd2;
            default:       key_col = 2'd3;   // 12, 13, 14, 15
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_s;
    logic [c_div_w-1:0] r_div_cnt;
    logic [1:0]         r_col;
    logic [15:0]        r_frame;
    logic [15:0]        r_candidate;
    logic [3:0]         r_stable_cnt;
    logic [15:0]        r_keys_raw;
    logic               r_keys_changed;

    logic               w_sample;
    logic               w_frame_end;
    logic [15:0]        w_frame_next;
    logic [3:0]         w_stable_next;
    logic               w_commit;

    // The last cycle of each column is the sample cycle; the sample cycle of
    // column 3 closes the frame.
    assign w_sample    = (r_div_cnt == c_div_last);
    assign w_frame_end = w_sample && (r_col == 2'd3);

    // ------------------------------------------------------------------------
    // Frame assembly: on the sample cycle, the four keys of the active column
    // take the inverted synchronised rows; all other bits hold. Every bit is
    // rewritten once per frame, so the frame never needs clearing.
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < 16; k++) begin : g_key
            localparam logic [1:0] c_row = key_row(k);
            localparam logic [1:0] c_col = key_col(k);

            assign w_frame_next[k] = (w_sample && (r_col == c_col)) ?
                                     ~r_row_s[c_row] : r_frame[k];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Debounce evaluation, using the complete frame including the column-3
    // bits captured this cycle. After evaluation the candidate always equals
    // the new frame, so the commit compares the frame itself to keys_raw.
    // ------------------------------------------------------------------------
    always_comb begin
        w_stable_next = r_stable_cnt;
        w_commit      = 1'b0;

        if (w_frame_next != r_candidate) begin
            w_stable_next = 4'd1;
        end else if (r_stable_cnt >= c_debounce) begin
            w_stable_next = c_debounce;
        end else begin
            w_stable_next = r_stable_cnt + 4'd1;
        end

        // Comparing against keys_raw suppresses repeat pulses for a held vector
        // and ignores a bounce that settles back to the committed value.
        w_commit = w_frame_end && (w_stable_next == c_debounce) &&
                   (w_frame_next != r_keys_raw);
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_meta     <= 4'hF;
            r_row_s        <= 4'hF;
            r_div_cnt      <= '0;
            r_col          <= 2'd0;
            r_frame        <= 16'h0000;
            r_candidate    <= 16'h0000;
            r_stable_cnt   <= 4'd0;
            r_keys_raw     <= 16'h0000;
            r_keys_changed <= 1'b0;
        end else begin
            // Two-stage synchroniser for the asynchronous row inputs.
            r_row_meta <= row_n;
            r_row_s    <= r_row_meta;

            // Column timing: the column advances on the same edge the divider
            // wraps, so col_n changes right after the sample cycle.
            if (w_sample) begin
                r_div_cnt <= '0;
                r_col     <= r_col + 2'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            r_frame <= w_frame_next;

            if (w_frame_end) begin
                r_candidate  <= w_frame_next;
                r_stable_cnt <= w_stable_next;
            end

            r_keys_changed <= w_commit;
            if (w_commit) begin
                r_keys_raw <= w_frame_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign col_n        = ~(4'b0001 << r_col);
    assign keys_raw     = r_keys_raw;
    assign keys_changed = r_keys_changed;

endmodule
`default_nettype wire

// File: tb/tb_chip8_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_chip8_keypad_scanner
// Purpose  : Self-checking bench for chip8_keypad_scanner with SCAN_DIV=8 and
//            DEBOUNCE_FRAMES=3 (32-cycle frames). A behavioural keypad matrix
//            pulls a row low while its column is driven and the key is held.
//            Every expected commit is pushed to a scoreboard queue with its
//            value and the exact cycle of its keys_changed pulse; a monitor
//            pops and compares on each pulse. Any pulse with nothing pending
//            is an error.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_chip8_keypad_scanner;

    localparam int SCAN_DIV        = 8;
    localparam int DEBOUNCE_FRAMES = 3;
    localparam int FRAME           = 4 * SCAN_DIV;
    localparam int LATENCY         = DEBOUNCE_FRAMES * FRAME;

    // Matrix layout: KMAP[row][col] = hex key
    localparam int KMAP [4][4] = '{'{ 1,  2,  3, 12},
                                   '{ 4,  5,  6, 13},
                                   '{ 7,  8,  9, 14},
                                   '{10,  0, 11, 15}};

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] keys_raw;
    logic        keys_changed;

    logic [15:0] held = 16'h0000;

    typedef struct {
        logic [15:0] val;
        int unsigned at;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    int unsigned cyc     = 0;
    int unsigned t0      = 0;
    logic        reset_q = 1'b1;
    logic        mon_en  = 1'b0;
    logic [15:0] prev_raw;
    int          checks  = 0;
    int          errors  = 0;

    chip8_keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .row_n        (row_n),
        .col_n        (col_n),
        .keys_raw     (keys_raw),
        .keys_changed (keys_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        reset_q <= reset;
    end

    // Keypad matrix: passive switches between a driven column and a row.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if ((col_n[c] === 1'b0) && held[KMAP[r][c]]) begin
                    row_n[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (mon_en && !reset_q) begin
            if (keys_raw !== prev_raw) begin
                check("raw_change_with_pulse", {31'd0, keys_changed}, 32'd1);
            end
            if (keys_changed === 1'b1) begin
                check("pulse_expected", {31'd0, (sb.size() > 0)}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("pulse_value", {16'd0, keys_raw}, {16'd0, e.val});
                    check("pulse_cycle", cyc, e.at);
                end
            end
        end
        prev_raw = keys_raw;
    end

    // Advance to the next frame start (just after the edge that starts it).
    task automatic frame_start();
        do begin
            @(posedge clk);
            #1;
        end while (((cyc - t0) % FRAME) != 0);
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(posedge clk);
        #1;
    endtask

    task automatic expect_commit(input logic [15:0] val);
        exp_t x;
        x.val = val;
        x.at  = cyc + LATENCY;
        sb.push_back(x);
    endtask

    initial begin
        logic [3:0] exp_col;

        // ---------------- Reset ----------------
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_col_n", {28'd0, col_n}, 32'h0000_000E);
        check("reset_keys_raw", {16'd0, keys_raw}, 32'h0000_0000);
        check("reset_keys_changed", {31'd0, keys_changed}, 32'd0);
        reset  = 1'b0;
        t0     = cyc;
        mon_en = 1'b1;

        // ---------------- Column sequence, two frames ----------------
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((i / SCAN_DIV) % 4));
            check("col_sequence", {28'd0, col_n}, {28'd0, exp_col});
        end
        frame_start();

        // ---------------- Hold key 5 ----------------
        held = 16'h0020;
        expect_commit(16'h0020);
        wait_frames(13);
        check("hold5_pending", sb.size(), 0);
        check("hold5_keys_raw", {16'd0, keys_raw}, 32'h0000_0020);

        // ---------------- Release key 5 ----------------
        held = 16'h0000;
        expect_commit(16'h0000);
        wait_frames(4);
        check("release5_pending", sb.size(), 0);
        check("release5_keys_raw", {16'd0, keys_raw}, 32'h0000_0000);

        // ---------------- Bounce: 2 on, 1 off, 2 on, off ----------------
        held = 16'h0020;
        wait_frames(2);
        held = 16'h0000;
        wait_frames(1);
        held = 16'h0020;
        wait_frames(2);
        held = 16'h0000;
        wait_frames(5);
        check("bounce_keys_raw", {16'd0, keys_raw}, 32'h0000_0000);

        // ---------------- Keys 0 + F, then add A ----------------
        held = 16'h8001;
        expect_commit(16'h8001);
        wait_frames(4);
        check("multi_pending", sb.size(), 0);
        check("multi_keys_raw", {16'd0, keys_raw}, 32'h0000_8001);

        held = 16'h8401;
        expect_commit(16'h8401);
        wait_frames(4);
        check("add_a_pending", sb.size(), 0);
        check("add_a_keys_raw", {16'd0, keys_raw}, 32'h0000_8401);

        held = 16'h0000;
        expect_commit(16'h0000);
        wait_frames(4);
        check("release_all_pending", sb.size(), 0);

        // ---------------- Reset mid-frame with key 5 committed ----------------
        held = 16'h0020;
        expect_commit(16'h0020);
        wait_frames(4);
        check("pre_reset_keys_raw", {16'd0, keys_raw}, 32'h0000_0020);
        repeat (13) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_keys_raw", {16'd0, keys_raw}, 32'h0000_0000);
        check("midreset_col_n", {28'd0, col_n}, 32'h0000_000E);
        check("midreset_keys_changed", {31'd0, keys_changed}, 32'd0);
        reset = 1'b0;
        t0    = cyc;
        expect_commit(16'h0020);
        wait_frames(2);
        check("recommit_not_early", {16'd0, keys_raw}, 32'h0000_0000);
        wait_frames(2);
        check("recommit_pending", sb.size(), 0);
        check("recommit_keys_raw", {16'd0, keys_raw}, 32'h0000_0020);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
